sram_ctrl: RTL

Parametrised controller between the Mips core's memory port and an external 16-bit asynchronous SRAM with per-byte masks. It accepts one word request at a time over a req/ack handshake. Each request becomes 1..HALVES 16-bit SRAM beats with programmable wait states, byte-lane masking and explicit tristate control of the shared data bus. Compared with the core's fixed single-halfword SRAM pins, it adds configurable word width (multi-beat), configurable wait states, beat skipping on masked writes, and a defined bus turnaround.

---
 rtl/sram_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - word-request to 16-bit async SRAM controller with wait states and byte masks
module sram_ctrl #(
   parameter int ADDR_W      = 18,
   parameter int HALVES      = 2,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [16*HALVES-1:0]  wdata,
   input  logic [2*HALVES-1:0]   be,
   output logic [16*HALVES-1:0]  rdata,
   output logic                  ack,
   output logic                  busy,
   output logic [ADDR_W-1:0]     sram_addr,
   inout  tri   [15:0]           sram_dq,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_ub_n,
   output logic                  sram_lb_n
);
   localparam int DW = 16 * HALVES;
   localparam int BW = 2 * HALVES;
   localparam int LG = (HALVES > 1) ? $clog2(HALVES) : 0;
   localparam int KW = (LG > 0) ? LG : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_ACCESS  = 3'd2;
   localparam logic [2:0] S_RECOVER = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]        state;
   logic [KW-1:0]     k;
   logic [3:0]        wcnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DW-1:0]     lat_wdata;
   logic [BW-1:0]     lat_be;
   logic [DW-1:0]     rdata_q;
   logic [ADDR_W-1:0] addr_q;

   logic [KW:0]       first_w;
   logic [KW:0]       next_beat;
   logic [KW-1:0]     start_k;
   logic              in_beat;
   logic              lane_lo;
   logic              lane_hi;
   logic [15:0]       beat_wdata;

   // Lowest beat at or above 'from' whose byte-enable pair is non-zero; MSB flags a hit.
   function automatic logic [KW:0] find_beat(input logic [BW-1:0] b, input int from);
      find_beat = '0;
      for (int j = HALVES - 1; j >= 0; j--) begin
         if (j >= from && b[2*j +: 2] != 2'b00) begin
            find_beat = {1'b1, KW'(j)};
         end
      end
   endfunction

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a, input logic [KW-1:0] kk);
      beat_addr = (a & ~ADDR_W'(HALVES - 1)) | ADDR_W'(kk);
   endfunction

   always_comb begin
      first_w    = find_beat(be, 0);
      start_k    = we ? first_w[KW-1:0] : '0;
      next_beat  = '0;
      if (lat_we) begin
         next_beat = find_beat(lat_be, int'(k) + 1);
      end else if (int'(k) < HALVES - 1) begin
         next_beat = {1'b1, k + KW'(1)};
      end
      in_beat    = (state == S_SETUP) || (state == S_ACCESS) || (state == S_RECOVER);
      lane_lo    = lat_be[2*int'(k)];
      lane_hi    = lat_be[2*int'(k) + 1];
      beat_wdata = lat_wdata[16*int'(k) +: 16];
   end

   assign ack       = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign rdata     = rdata_q;
   assign sram_addr = addr_q;
   assign sram_ce_n = !in_beat;
   assign sram_oe_n = !((state == S_ACCESS) && !lat_we);
   assign sram_we_n = !((state == S_ACCESS) && lat_we);
   assign sram_lb_n = !(in_beat && (!lat_we || lane_lo));
   assign sram_ub_n = !(in_beat && (!lat_we || lane_hi));
   // Reads never drive the bus; the RECOVER cycle gives the SRAM time to release it.
   assign sram_dq   = (in_beat && lat_we) ? beat_wdata : 16'bz;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         k         <= '0;
         wcnt      <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         rdata_q   <= '0;
         addr_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  lat_we    <= we;
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  lat_be    <= be;
                  if (we && be == '0) begin
                     state <= S_DONE;
                  end else begin
                     k      <= start_k;
                     addr_q <= beat_addr(addr, start_k);
                     state  <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               wcnt  <= '0;
               state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (wcnt == 4'(WAIT_STATES)) begin
                  if (!lat_we) begin
                     rdata_q[16*int'(k) +: 16] <= sram_dq;
                  end
                  state <= S_RECOVER;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            S_RECOVER: begin
               if (next_beat[KW]) begin
                  k      <= next_beat[KW-1:0];
                  addr_q <= beat_addr(lat_addr, next_beat[KW-1:0]);
                  state  <= S_SETUP;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
